// File: rtl/plic_reg_access_if.sv
`default_nettype none
// ============================================================================
//  Module      : plic_reg_access_if
//  Description : SRAM-style request/response bus between the PLIC APB bridge
//                and the register engine.
//  Revision    : 1.0 - initial release
// ============================================================================
interface plic_reg_access_if #(
   parameter int MEM_ADDR_WIDTH = 13
);
   logic                      mem_csb_i;
   logic                      mem_rwb_i;
   logic [MEM_ADDR_WIDTH-1:0] mem_addr_i;
   logic [3:0]                mem_wm_i;
   logic [31:0]               mem_wdata_i;
   logic                      pri_acc_i;
   logic                      mem_rdy_o;
   logic [31:0]               mem_rdata_o;
   logic                      error_o;

   modport master (
      output mem_csb_i, mem_rwb_i, mem_addr_i, mem_wm_i, mem_wdata_i, pri_acc_i,
      input  mem_rdy_o, mem_rdata_o, error_o
   );

   modport slave (
      input  mem_csb_i, mem_rwb_i, mem_addr_i, mem_wm_i, mem_wdata_i, pri_acc_i,
      output mem_rdy_o, mem_rdata_o, error_o
   );
endinterface
`default_nettype wire

// File: rtl/plic_reg_access.sv
`default_nettype none
// ============================================================================
//  Module      : plic_reg_access
//  Description : PLIC register engine: decodes bridge requests into priority/
//                enable SRAM, threshold flops and the claim/complete handshake.
//                Define PLIC_REG_PRIV_CHK_EN to reject unprivileged writes.
//  Revision    : 1.0 - initial release
// ============================================================================
module plic_reg_access #(
   parameter  int NUM_CTX        = 4,
   parameter  int PRIO_W         = 3,
   parameter  int MEM_ADDR_WIDTH = 13,
   parameter  int CLAIM_TO       = 15,
   localparam int CTX_W          = (NUM_CTX > 1) ? $clog2(NUM_CTX) : 1
) (
   input  wire logic                      gated_clk,
   input  wire logic                      prst_n_i,
   plic_reg_access_if.slave               bus,
   output logic                           sram_cs_o,
   output logic                           sram_we_o,
   output logic [6:0]                     sram_addr_o,
   output logic [3:0]                     sram_bwe_o,
   output logic [31:0]                    sram_wdata_o,
   input  wire logic [31:0]               sram_rdata_i,
   input  wire logic [63:0]               pending_i,
   output logic [NUM_CTX*PRIO_W-1:0]      thr_o,
   output logic                           claim_req_o,
   output logic [CTX_W-1:0]               claim_ctx_o,
   input  wire logic                      claim_ack_i,
   input  wire logic [5:0]                claim_id_i,
   output logic                           complete_vld_o,
   output logic [5:0]                     complete_id_o
);

   localparam logic [7:0] c_CLAIM_TO = 8'(CLAIM_TO);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      S_RD   = 3'd1,
      S_WAIT = 3'd2,
      S_WR   = 3'd3,
      CLAIM  = 3'd4,
      RESP   = 3'd5
   } state_t;

   state_t r_state;
   state_t w_state_nxt;

   logic [31:0]       r_rdata;
   logic              r_err;
   logic [6:0]        r_sram_idx;
   logic [3:0]        r_wm;
   logic [31:0]       r_wdata;
   logic [7:0]        r_cnt;
   logic [CTX_W-1:0]  r_ctx;
   logic              r_cmpl_vld;
   logic [5:0]        r_cmpl_id;
   logic [PRIO_W-1:0] r_thr [NUM_CTX];

   logic [MEM_ADDR_WIDTH-1:0] w_addr;
   logic [12:0]       w_a;
   logic              w_is_prio;
   logic              w_is_pend;
   logic              w_is_en;
   logic              w_is_ctx;
   logic [8:0]        w_ctx_raw;
   logic              w_ctx_ok;
   logic              w_dec_err;
   logic              w_priv_err;
   logic              w_err;
   logic [CTX_W-1:0]  w_ctx;
   logic              w_sram_hit;
   logic              w_claim_rd;
   logic [6:0]        w_sram_idx;
   logic [31:0]       w_sram_wdata;
   logic [31:0]       w_pend_word;
   logic              w_unused;

   assign w_addr   = bus.mem_addr_i;
   assign w_unused = &{1'b0, w_addr, pending_i[0], bus.pri_acc_i};

   // Address decode of the live request; only consumed in IDLE.
   always_comb begin
      w_a       = w_addr[12:0];
      w_is_prio = (w_a[12:8] == 5'd0);
      w_is_pend = (w_a[12:3] == 10'h080);
      w_is_en   = (w_a[12:11] == 2'b01);
      w_is_ctx  = w_a[12];
      w_ctx_raw = w_a[12] ? w_a[11:3] : {1'b0, w_a[10:3]};
      w_ctx_ok  = (int'(w_ctx_raw) < NUM_CTX);
      w_dec_err = !(w_is_prio || (w_is_pend && !bus.mem_rwb_i) ||
                    ((w_is_en || w_is_ctx) && w_ctx_ok));
`ifdef PLIC_REG_PRIV_CHK_EN
      w_priv_err = bus.mem_rwb_i && !bus.pri_acc_i;
`else
      w_priv_err = 1'b0;
`endif
      w_err        = w_dec_err || w_priv_err;
      w_ctx        = w_ctx_raw[CTX_W-1:0];
      w_sram_hit   = !w_err && ((w_is_prio && (w_a[7:2] != 6'd0)) || w_is_en);
      w_claim_rd   = !w_err && w_is_ctx && w_a[2] && !bus.mem_rwb_i;
      w_sram_idx   = w_is_prio ? {1'b0, w_a[7:2]} : {1'b1, w_ctx_raw[4:0], w_a[2]};
      w_sram_wdata = w_is_prio ? 32'(bus.mem_wdata_i[PRIO_W-1:0]) : bus.mem_wdata_i;
      w_pend_word  = w_a[2] ? pending_i[63:32] : {pending_i[31:1], 1'b0};
   end

   always_ff @(posedge gated_clk or negedge prst_n_i) begin
      if (!prst_n_i) r_state <= IDLE;
      else           r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt   = r_state;
      bus.mem_rdy_o = 1'b0;
      sram_cs_o     = 1'b0;
      sram_we_o     = 1'b0;
      sram_addr_o   = '0;
      sram_bwe_o    = '0;
      sram_wdata_o  = '0;
      claim_req_o   = 1'b0;
      case (r_state)
         IDLE: begin
            bus.mem_rdy_o = 1'b1;
            if (!bus.mem_csb_i) begin
               if (w_sram_hit)      w_state_nxt = bus.mem_rwb_i ? S_WR : S_RD;
               else if (w_claim_rd) w_state_nxt = CLAIM;
               else                 w_state_nxt = RESP;
            end
         end
         S_RD: begin
            sram_cs_o   = 1'b1;
            sram_addr_o = r_sram_idx;
            w_state_nxt = S_WAIT;
         end
         S_WAIT: w_state_nxt = RESP;
         S_WR: begin
            sram_cs_o    = 1'b1;
            sram_we_o    = 1'b1;
            sram_addr_o  = r_sram_idx;
            sram_bwe_o   = r_wm;
            sram_wdata_o = r_wdata;
            w_state_nxt  = RESP;
         end
         CLAIM: begin
            claim_req_o = 1'b1;
            if ((r_cnt == c_CLAIM_TO) || claim_ack_i) w_state_nxt = RESP;
         end
         RESP: begin
            bus.mem_rdy_o = 1'b1;
            w_state_nxt   = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge gated_clk or negedge prst_n_i) begin
      if (!prst_n_i) begin
         r_rdata    <= '0;
         r_err      <= 1'b0;
         r_sram_idx <= '0;
         r_wm       <= '0;
         r_wdata    <= '0;
         r_cnt      <= '0;
         r_ctx      <= '0;
         r_cmpl_vld <= 1'b0;
         r_cmpl_id  <= '0;
         for (int i = 0; i < NUM_CTX; i++) r_thr[i] <= '0;
      end else begin
         r_cmpl_vld <= 1'b0;
         case (r_state)
            IDLE: begin
               if (!bus.mem_csb_i) begin
                  r_rdata    <= '0;
                  r_err      <= w_err;
                  r_sram_idx <= w_sram_idx;
                  r_wm       <= bus.mem_wm_i;
                  r_wdata    <= w_sram_wdata;
                  if (!w_err) begin
                     if (w_is_pend) begin
                        r_rdata <= w_pend_word;
                     end else if (w_is_ctx && !w_a[2]) begin
                        if (!bus.mem_rwb_i)       r_rdata <= 32'(r_thr[w_ctx]);
                        else if (bus.mem_wm_i[0]) r_thr[w_ctx] <= bus.mem_wdata_i[PRIO_W-1:0];
                     end else if (w_is_ctx) begin
                        r_ctx <= w_ctx;
                        // A complete with byte 0 masked off is silently dropped.
                        if (bus.mem_rwb_i && bus.mem_wm_i[0]) begin
                           r_cmpl_vld <= 1'b1;
                           r_cmpl_id  <= bus.mem_wdata_i[5:0];
                        end
                     end
                  end
               end
            end
            S_WAIT: r_rdata <= sram_rdata_i;
            CLAIM: begin
               // Timeout wins over a late ack arriving in the same cycle.
               if (r_cnt == c_CLAIM_TO) begin
                  r_rdata <= '0;
                  r_cnt   <= '0;
               end else if (claim_ack_i) begin
                  r_rdata <= {26'b0, claim_id_i};
                  r_cnt   <= '0;
               end else begin
                  r_cnt <= r_cnt + 8'd1;
               end
            end
            default: ;
         endcase
      end
   end

   generate
      for (genvar g = 0; g < NUM_CTX; g++) begin : g_thr
         assign thr_o[g*PRIO_W +: PRIO_W] = r_thr[g];
      end
   endgenerate

   assign bus.mem_rdata_o = r_rdata;
   assign bus.error_o     = r_err;
   assign claim_ctx_o     = r_ctx;
   assign complete_vld_o  = r_cmpl_vld;
   assign complete_id_o   = r_cmpl_id;

endmodule
`default_nettype wire

// File: tb/tb_plic_reg_access.sv
`default_nettype none
// ============================================================================
//  Module      : tb_plic_reg_access
//  Description : Directed self-checking bench for plic_reg_access.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_plic_reg_access;

   localparam int c_NUM_CTX = 4;
   localparam int c_PRIO_W  = 3;
   localparam int c_TO      = 15;

   logic        gated_clk;
   logic        prst_n_i;
   logic        sram_cs_o, sram_we_o;
   logic [6:0]  sram_addr_o;
   logic [3:0]  sram_bwe_o;
   logic [31:0] sram_wdata_o;
   logic [31:0] sram_rdata_i;
   logic [63:0] pending_i;
   logic [11:0] thr_o;
   logic        claim_req_o;
   logic [1:0]  claim_ctx_o;
   logic        claim_ack_i;
   logic [5:0]  claim_id_i;
   logic        complete_vld_o;
   logic [5:0]  complete_id_o;

   plic_reg_access_if #(.MEM_ADDR_WIDTH(13)) bus ();

   plic_reg_access #(
      .NUM_CTX(c_NUM_CTX), .PRIO_W(c_PRIO_W), .MEM_ADDR_WIDTH(13), .CLAIM_TO(c_TO)
   ) dut (
      .gated_clk(gated_clk), .prst_n_i(prst_n_i), .bus(bus),
      .sram_cs_o(sram_cs_o), .sram_we_o(sram_we_o), .sram_addr_o(sram_addr_o),
      .sram_bwe_o(sram_bwe_o), .sram_wdata_o(sram_wdata_o), .sram_rdata_i(sram_rdata_i),
      .pending_i(pending_i), .thr_o(thr_o),
      .claim_req_o(claim_req_o), .claim_ctx_o(claim_ctx_o),
      .claim_ack_i(claim_ack_i), .claim_id_i(claim_id_i),
      .complete_vld_o(complete_vld_o), .complete_id_o(complete_id_o)
   );

   initial gated_clk = 1'b0;
   always #5 gated_clk = ~gated_clk;

   // Behavioural SRAM: byte-masked write, read data one cycle after select.
   logic [31:0] mem [128];
   int          wr_cnt;
   logic [6:0]  wr_idx;
   logic [31:0] wr_data;
   logic [3:0]  wr_bwe;
   initial begin
      for (int i = 0; i < 128; i++) mem[i] = '0;
      wr_cnt = 0; wr_idx = '0; wr_data = '0; wr_bwe = '0;
      sram_rdata_i = '0;
   end
   always @(posedge gated_clk) begin
      if (sram_cs_o && sram_we_o) begin
         for (int b = 0; b < 4; b++)
            if (sram_bwe_o[b]) mem[sram_addr_o][b*8 +: 8] <= sram_wdata_o[b*8 +: 8];
         wr_cnt  <= wr_cnt + 1;
         wr_idx  <= sram_addr_o;
         wr_data <= sram_wdata_o;
         wr_bwe  <= sram_bwe_o;
      end else if (sram_cs_o) begin
         sram_rdata_i <= mem[sram_addr_o];
      end
   end

   int         cyc;
   int         req_cnt;
   int         cmpl_cnt;
   int         cmpl_cyc;
   logic [1:0] cmpl_ctx;
   logic [5:0] cmpl_id;
   int         t_req;
   initial begin
      cyc = 0; req_cnt = 0; cmpl_cnt = 0; cmpl_cyc = -1; cmpl_ctx = '0; cmpl_id = '0; t_req = 0;
   end
   always @(posedge gated_clk) cyc++;
   always @(negedge gated_clk) begin
      if (claim_req_o) req_cnt++;
      if (complete_vld_o) begin
         cmpl_cnt++;
         cmpl_cyc = cyc;
         cmpl_ctx = claim_ctx_o;
         cmpl_id  = complete_id_o;
      end
   end

   int n_checks;
   int n_fail;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Issues one request from cycle T; returns cycles until rdy and the response.
   task automatic access(input logic rwb, input logic [12:0] addr, input logic [3:0] wm,
                         input logic [31:0] wd, input logic pri,
                         output int lat, output logic [31:0] rd, output logic er);
      bus.mem_csb_i   = 1'b0;
      bus.mem_rwb_i   = rwb;
      bus.mem_addr_i  = addr;
      bus.mem_wm_i    = wm;
      bus.mem_wdata_i = wd;
      bus.pri_acc_i   = pri;
      @(posedge gated_clk); #1;
      t_req = cyc;
      bus.mem_csb_i = 1'b1;
      lat = 1;
      while (!bus.mem_rdy_o && lat < 400) begin
         @(posedge gated_clk); #1;
         lat++;
      end
      rd = bus.mem_rdata_o;
      er = bus.error_o;
      @(posedge gated_clk); #1;
   endtask

   int          lat;
   logic [31:0] rd;
   logic        er;
   int          wr_before;

   initial begin
      n_checks = 0; n_fail = 0;
      prst_n_i = 1'b0;
      bus.mem_csb_i = 1'b1; bus.mem_rwb_i = 1'b0; bus.mem_addr_i = '0;
      bus.mem_wm_i = '0; bus.mem_wdata_i = '0; bus.pri_acc_i = 1'b1;
      pending_i = 64'hF0F0_0000_1234_5679;
      claim_ack_i = 1'b0; claim_id_i = '0;
      #2;
      check("rst_rdy", bus.mem_rdy_o, 1);
      check("rst_rdata", bus.mem_rdata_o, 0);
      check("rst_err", bus.error_o, 0);
      check("rst_thr", thr_o, 0);
      check("rst_sram", {sram_cs_o, sram_we_o, sram_addr_o, sram_bwe_o, sram_wdata_o}, 0);
      check("rst_claim", {claim_req_o, claim_ctx_o, complete_vld_o, complete_id_o}, 0);
      @(posedge gated_clk); @(posedge gated_clk); #1;
      prst_n_i = 1'b1;
      @(posedge gated_clk); #1;

      // Priority entry 2
      access(1, 13'h0008, 4'hF, 32'h5, 1, lat, rd, er);
      check("prio_wr_lat", lat, 2);
      check("prio_wr_err", er, 0);
      check("prio_wr_idx", wr_idx, 2);
      check("prio_wr_data", wr_data, 5);
      check("prio_wr_bwe", wr_bwe, 4'hF);
      access(0, 13'h0008, 4'h0, 32'h0, 1, lat, rd, er);
      check("prio_rd_lat", lat, 3);
      check("prio_rd_data", rd, 5);
      check("prio_rd_err", er, 0);
      // Priority data masked to PRIO_W bits
      access(1, 13'h000C, 4'hF, 32'hFF, 1, lat, rd, er);
      access(0, 13'h000C, 4'h0, 32'h0, 1, lat, rd, er);
      check("prio_mask", rd, 7);

      // Enable word 1 of context 1 -> index 67, only low two bytes
      access(1, 13'h080C, 4'h3, 32'hDEAD_BEEF, 1, lat, rd, er);
      check("en_wr_idx", wr_idx, 67);
      access(0, 13'h080C, 4'h0, 32'h0, 1, lat, rd, er);
      check("en_rd_data", rd, 32'h0000_BEEF);

      // Threshold context 1
      access(1, 13'h1008, 4'hF, 32'h7, 1, lat, rd, er);
      check("thr_wr_lat", lat, 1);
      check("thr_o", thr_o, 12'h038);
      access(1, 13'h1008, 4'hE, 32'h2, 1, lat, rd, er);
      check("thr_wm0", thr_o, 12'h038);
      access(0, 13'h1008, 4'h0, 32'h0, 1, lat, rd, er);
      check("thr_rd_lat", lat, 1);
      check("thr_rd_data", rd, 7);

      // Pending words
      access(0, 13'h0400, 4'h0, 32'h0, 1, lat, rd, er);
      check("pend_lo", rd, 32'h1234_5678);
      check("pend_lat", lat, 1);
      access(0, 13'h0404, 4'h0, 32'h0, 1, lat, rd, er);
      check("pend_hi", rd, 32'hF0F0_0000);

      // Decode errors
      access(0, 13'h0FF0, 4'h0, 32'h0, 1, lat, rd, er);
      check("bad_rd_err", er, 1);
      check("bad_rd_data", rd, 0);
      check("bad_rd_lat", lat, 1);
      access(1, 13'h0404, 4'hF, 32'h1, 1, lat, rd, er);
      check("pend_wr_err", er, 1);
      check("pend_wr_lat", lat, 1);
      access(0, 13'h1020, 4'h0, 32'h0, 1, lat, rd, er);
      check("ctx_range_err", er, 1);

      // Priority 0: dropped write, reads zero
      wr_before = wr_cnt;
      access(1, 13'h0000, 4'hF, 32'h3, 1, lat, rd, er);
      check("p0_wr_err", er, 0);
      check("p0_wr_lat", lat, 1);
      check("p0_no_sram", wr_cnt, wr_before);
      access(0, 13'h0000, 4'h0, 32'h0, 1, lat, rd, er);
      check("p0_rd", rd, 0);

      // Claim with ack in the fourth CLAIM cycle
      req_cnt = 0;
      fork
         access(0, 13'h1004, 4'h0, 32'h0, 1, lat, rd, er);
         begin
            repeat (4) @(posedge gated_clk);
            #1;
            claim_ack_i = 1'b1; claim_id_i = 6'h21;
            @(posedge gated_clk); #1;
            claim_ack_i = 1'b0; claim_id_i = '0;
         end
      join
      check("claim_lat", lat, 5);
      check("claim_req_cyc", req_cnt, 4);
      check("claim_data", rd, 32'h21);
      check("claim_err", er, 0);

      // Claim timeout on context 2
      req_cnt = 0;
      access(0, 13'h1014, 4'h0, 32'h0, 1, lat, rd, er);
      check("to_lat", lat, 2 + c_TO);
      check("to_req_cyc", req_cnt, c_TO + 1);
      check("to_data", rd, 0);
      check("to_err", er, 0);
      check("to_ctx", claim_ctx_o, 2);

      // Complete on context 1
      access(1, 13'h100C, 4'h1, 32'h2A, 1, lat, rd, er);
      check("cmpl_lat", lat, 1);
      check("cmpl_cnt", cmpl_cnt, 1);
      check("cmpl_time", cmpl_cyc, t_req);
      check("cmpl_ctx", cmpl_ctx, 1);
      check("cmpl_id", cmpl_id, 6'h2A);
      access(1, 13'h100C, 4'hE, 32'h15, 1, lat, rd, er);
      check("cmpl_wm0_drop", cmpl_cnt, 1);

      // Unprivileged write
      wr_before = wr_cnt;
      access(1, 13'h0008, 4'hF, 32'h6, 0, lat, rd, er);
`ifdef PLIC_REG_PRIV_CHK_EN
      check("priv_err", er, 1);
      check("priv_lat", lat, 1);
      check("priv_no_sram", wr_cnt, wr_before);
`else
      check("priv_err", er, 0);
      check("priv_lat", lat, 2);
      check("priv_sram", wr_cnt, wr_before + 1);
`endif

      // Reset in the middle of a claim
      bus.mem_csb_i = 1'b0; bus.mem_rwb_i = 1'b0; bus.mem_addr_i = 13'h1004;
      bus.pri_acc_i = 1'b1;
      @(posedge gated_clk); #1;
      bus.mem_csb_i = 1'b1;
      @(posedge gated_clk); #1;
      check("mid_claim_req", claim_req_o, 1);
      check("mid_claim_rdy", bus.mem_rdy_o, 0);
      wr_before = wr_cnt;
      #2 prst_n_i = 1'b0;
      #1;
      check("rst_mid_req", claim_req_o, 0);
      check("rst_mid_rdy", bus.mem_rdy_o, 1);
      check("rst_mid_thr", thr_o, 0);
      @(posedge gated_clk); #1;
      prst_n_i = 1'b1;
      @(posedge gated_clk); #1;
      check("rst_mid_no_sram", wr_cnt, wr_before);
      access(0, 13'h1008, 4'h0, 32'h0, 1, lat, rd, er);
      check("rst_thr_rd", rd, 0);
      check("rst_no_cmpl", cmpl_cnt, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
